alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one combinational 32-bit ALU (ADD/SUB/AND/OR/SLT, 3-bit control, Z/N/V/C flags) among NREQ requesters.
- Accepts one operation per grant and drives the ALU from registered operands.
- Captures the result and flags, then returns them with the requester ID on a valid/ready response channel.
- Sits between the core-side clients (address generation, branch compare, debug/CSR helpers) and the single shared ALU instance.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, response ID width; must satisfy 2**IDW >= NREQ

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous active-low reset (0 = reset)
- req_valid  in  NREQ  per-requester operation valid
- req_ready  out  NREQ  per-requester accept; at most one bit high
- req_a  in  NREQ*32  operand A, requester i at bits [32i+31:32i]
- req_b  in  NREQ*32  operand B, same packing
- req_op  in  NREQ*3  ALU control, requester i at bits [3i+2:3i]
- alu_a  out  32  operand A to the ALU
- alu_b  out  32  operand B to the ALU
- alu_ctrl  out  3  ALU control
- alu_result  in  32  ALU result
- alu_z, alu_n, alu_v, alu_c  in  1 each  ALU flags
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  IDW  index of the requester that issued the operation
- rsp_result  out  32  captured result
- rsp_flags  out  4  captured flags {Z,N,V,C}
- rsp_err  out  1  op code was not in {000,001,010,011,101}

Behaviour:
- Reset (rst=0, async): state=IDLE, rr_ptr=0, and all outputs 0 (req_ready, alu_a/b/ctrl, rsp_*).
- An operation in flight at reset is dropped; no response is produced.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, scanning from rr_ptr upward and wrapping modulo NREQ.
  - req_ready[winner]=1 is combinational, in the same cycle, and only in IDLE.
  - On the accepting edge: latch a/b/op into the operand registers, latch the winner into id_q, set rr_ptr=(winner+1) mod NREQ, go to EXEC.
  - No valid request: stay in IDLE; rr_ptr unchanged.
- EXEC:
  - alu_a/alu_b/alu_ctrl are driven from the operand registers. They are held constant in every state and change only when the next operation is accepted.
  - On the edge: rsp_result<=alu_result, rsp_flags<={alu_z,alu_n,alu_v,alu_c}, rsp_id<=id_q, rsp_err<=illegal op; go to RESP.
- RESP:
  - rsp_valid=1, with rsp_* stable until the handshake.
  - rsp_valid and rsp_ready both 1 -> IDLE; otherwise hold (backpressure, unbounded).
- Latency: accept at edge T, rsp_valid high from cycle T+2. Peak throughput is 1 op per 3 cycles.
- Requester protocol: once req_valid is raised, valid and operands are held until req_ready; de-asserting early is permitted and simply loses arbitration.
- req_ready is always 0 in EXEC and RESP.
- Illegal op (100, 110, 111): still issued. rsp_result is forced to 0, rsp_flags to 4'b1000, and rsp_err=1.
- All requesters valid every cycle: grants rotate 0,1,2,3,0,...
- A single requester is granted on every IDLE visit, regardless of rr_ptr.
- rsp_ready high in the same cycle rsp_valid rises completes the handshake in that cycle; the next grant can occur in the following IDLE cycle.

Optional Feature:
- Macro: ALU_SHARE_ARB_PERF_EN.
- Defined:
  - Adds output perf_ops [31:0], the count of completed response handshakes, saturating at 32'hFFFFFFFF.
  - Adds output perf_stall [31:0], the count of cycles in RESP with rsp_ready=0, also saturating.
  - Both reset to 0.
- Not defined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Reset: rst=0 mid-EXEC -> req_ready=0, rsp_valid=0, alu_ctrl=0 immediately. After release, requester 0 valid -> granted first (rr_ptr=0).
- Single op: req 1 issues A=5, B=3, op=001 at T -> rsp_valid at T+2, rsp_id=1, rsp_result=2, flags Z=0, N=0, C=1, V=0, rsp_err=0.
- Round-robin: all 4 requesters valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0; each requester's req_ready is a single-cycle pulse.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, no req_ready asserted. Release -> handshake, then the next grant one cycle later. With PERF_EN: perf_stall=5, perf_ops=1.
- SLT/zero: A=32'hFFFFFFFF, B=1, op=101 -> rsp_result=1. A=B=7, op=001 -> rsp_result=0, Z=1.
- Illegal op 110 with A=B=9 -> rsp_result=0, rsp_flags=4'b1000, rsp_err=1; rr_ptr advances normally.

Source files
------------

// File: rtl/alu_share_arb_if.sv
// alu_share_arb_if: request, shared-ALU and response signals of alu_share_arb.
// slave  = the arbiter side; master = requesters + ALU + response consumer.
interface alu_share_arb_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
);
    // Request channel, one lane per requester
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ*3-1:0]  req_op;

    // Shared ALU
    logic [31:0]        alu_a;
    logic [31:0]        alu_b;
    logic [2:0]         alu_ctrl;
    logic [31:0]        alu_result;
    logic               alu_z;
    logic               alu_n;
    logic               alu_v;
    logic               alu_c;

    // Response channel
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_result;
    logic [3:0]         rsp_flags;
    logic               rsp_err;

    modport slave (
        input  req_valid, req_a, req_b, req_op,
        input  alu_result, alu_z, alu_n, alu_v, alu_c,
        input  rsp_ready,
        output req_ready, alu_a, alu_b, alu_ctrl,
        output rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
    );

    modport master (
        output req_valid, req_a, req_b, req_op,
        output alu_result, alu_z, alu_n, alu_v, alu_c,
        output rsp_ready,
        input  req_ready, alu_a, alu_b, alu_ctrl,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
    );
endinterface

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin arbiter/sequencer sharing one combinational ALU among NREQ
// requesters. One op per grant: IDLE (grant) -> EXEC (ALU evaluates) -> RESP (hold result).
// Optional: define ALU_SHARE_ARB_PERF_EN to add perf_ops / perf_stall counters.
module alu_share_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic           clk,
    input  logic           rst,
    alu_share_arb_if.slave bus
`ifdef ALU_SHARE_ARB_PERF_EN
    ,
    output logic [31:0]    perf_ops,
    output logic [31:0]    perf_stall
`endif
);
    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e          state_q;
    logic [IDW-1:0]  rr_ptr_q;
    logic [IDW-1:0]  id_q;
    logic [31:0]     op_a_q;
    logic [31:0]     op_b_q;
    logic [2:0]      op_q;
    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [31:0]     rsp_result_q;
    logic [3:0]      rsp_flags_q;
    logic            rsp_err_q;

    logic            found;
    logic [IDW-1:0]  winner;
    logic [IDW-1:0]  rr_ptr_next;
    logic [NREQ-1:0] ready_vec;
    logic            illegal_op;

    // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
            if (!found && bus.req_valid[idx[IDW-1:0]]) begin
                found  = 1'b1;
                winner = idx[IDW-1:0];
            end
        end
    end

    // Pointer moves just past the winner so it has lowest priority next round.
    always_comb begin
        rr_ptr_next = winner + IDW'(1);
        if (int'(winner) == int'(NREQ) - 1) rr_ptr_next = '0;
    end

    // Grant is combinational in IDLE only; gated by reset so every output is 0 in reset.
    always_comb begin
        ready_vec = '0;
        if (rst && (state_q == StIdle) && found) ready_vec[winner] = 1'b1;
    end

    // Legal op codes are 000, 001, 010, 011 and 101.
    always_comb begin
        illegal_op = op_q[2] && (op_q != 3'b101);
    end

    // Sequencer FSM: latch operands on grant, sample ALU in EXEC, hold response in RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (found) begin
                        op_a_q   <= bus.req_a[32*winner +: 32];
                        op_b_q   <= bus.req_b[32*winner +: 32];
                        op_q     <= bus.req_op[3*winner +: 3];
                        id_q     <= winner;
                        rr_ptr_q <= rr_ptr_next;
                        state_q  <= StExec;
                    end
                end
                StExec: begin
                    if (illegal_op) begin
                        rsp_result_q <= '0;
                        rsp_flags_q  <= 4'b1000;
                    end else begin
                        rsp_result_q <= bus.alu_result;
                        rsp_flags_q  <= {bus.alu_z, bus.alu_n, bus.alu_v, bus.alu_c};
                    end
                    rsp_id_q    <= id_q;
                    rsp_err_q   <= illegal_op;
                    rsp_valid_q <= 1'b1;
                    state_q     <= StResp;
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ready  = ready_vec;
    assign bus.alu_a      = op_a_q;
    assign bus.alu_b      = op_b_q;
    assign bus.alu_ctrl   = op_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;
    assign bus.rsp_err    = rsp_err_q;

`ifdef ALU_SHARE_ARB_PERF_EN
    logic [31:0] perf_ops_q;
    logic [31:0] perf_stall_q;

    // Saturating counters: completed handshakes and backpressured RESP cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else if (state_q == StResp) begin
            if (bus.rsp_ready) begin
                if (perf_ops_q != '1) perf_ops_q <= perf_ops_q + 32'd1;
            end else begin
                if (perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`endif
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed tests for alu_share_arb with a bench-side 32-bit ALU.
module tb_alu_share_arb;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_share_arb_if #(.NREQ(4), .IDW(2)) bus ();

`ifdef ALU_SHARE_ARB_PERF_EN
    logic [31:0] perf_ops;
    logic [31:0] perf_stall;
    alu_share_arb #(.NREQ(4), .IDW(2)) dut (
        .clk(clk), .rst(rst), .bus(bus), .perf_ops(perf_ops), .perf_stall(perf_stall)
    );
`else
    alu_share_arb #(.NREQ(4), .IDW(2)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU: 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT.
    // Undefined controls produce a+b with C=1 so forced illegal results are observable.
    always_comb begin
        logic [32:0] s;
        logic [31:0] r;
        logic        c;
        logic        v;
        s = '0;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (bus.alu_ctrl)
            3'b000: begin
                s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                r = s[31:0];
                c = s[32];
                v = (bus.alu_a[31] == bus.alu_b[31]) && (r[31] != bus.alu_a[31]);
            end
            3'b001: begin
                s = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
                r = s[31:0];
                c = s[32];
                v = (bus.alu_a[31] != bus.alu_b[31]) && (r[31] != bus.alu_a[31]);
            end
            3'b010: r = bus.alu_a & bus.alu_b;
            3'b011: r = bus.alu_a | bus.alu_b;
            3'b101: r = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
            default: begin
                r = bus.alu_a + bus.alu_b;
                c = 1'b1;
            end
        endcase
        bus.alu_result = r;
        bus.alu_z      = (r == 32'd0);
        bus.alu_n      = r[31];
        bus.alu_v      = v;
        bus.alu_c      = c;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op);
        bus.req_a[32*i +: 32] = a;
        bus.req_b[32*i +: 32] = b;
        bus.req_op[3*i +: 3]  = op;
        bus.req_valid[i]      = 1'b1;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        set_req(0, 32'h12, 32'h21, 3'b011);
        set_req(2, 32'h40, 32'h02, 3'b000);
        #1;
        checks++;
        if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b0 || bus.alu_ctrl !== 3'd0 ||
            bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b rsp_valid=%b ctrl=%0d a=%h b=%h, need all 0",
                     bus.req_ready, bus.rsp_valid, bus.alu_ctrl, bus.alu_a, bus.alu_b);
        end
        checks++;
        if (bus.rsp_id !== 2'd0 || bus.rsp_result !== 32'd0 || bus.rsp_flags !== 4'd0 ||
            bus.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp: id=%0d result=%h flags=%b err=%b, need all 0",
                     bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err);
        end
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_grant: req_ready=%b need 0001", bus.req_ready);
        end
        tick();  // req 0 accepted (OR), now in EXEC; ptr=1
        checks++;
        if (bus.alu_ctrl !== 3'b011) begin
            errors++;
            $display("FAIL exec_ctrl: alu_ctrl=%b need 011", bus.alu_ctrl);
        end
        rst = 1'b0;  // reset mid-EXEC
        #1;
        checks++;
        if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b0 || bus.alu_ctrl !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_exec: ready=%b rsp_valid=%b ctrl=%b need 0000/0/000",
                     bus.req_ready, bus.rsp_valid, bus.alu_ctrl);
        end
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_regrant: ready=%b rsp_valid=%b need 0001/0",
                     bus.req_ready, bus.rsp_valid);
        end
        tick();
        bus.req_valid = 4'b0000;
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL dropped_op: rsp_valid=%b need 0", bus.rsp_valid);
        end
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_result !== 32'h33) begin
            errors++;
            $display("FAIL reset_rsp0: valid=%b id=%0d result=%h need 1/0/00000033",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_result);
        end
        bus.rsp_ready = 1'b1;
        tick();
    endtask

    task automatic test_single_op();
        set_req(1, 32'd5, 32'd3, 3'b001);
        #1;
        checks++;
        if (bus.req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL single_grant: req_ready=%b need 0010", bus.req_ready);
        end
        tick();
        bus.req_valid = 4'b0000;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.alu_a !== 32'd5 || bus.alu_b !== 32'd3 ||
            bus.alu_ctrl !== 3'b001 || bus.req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL single_exec: valid=%b a=%h b=%h ctrl=%b ready=%b need 0/5/3/001/0000",
                     bus.rsp_valid, bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.req_ready);
        end
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_result !== 32'd2 ||
            bus.rsp_flags !== 4'b0001 || bus.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp: valid=%b id=%0d result=%h flags=%b err=%b need 1/1/2/0001/0",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err);
        end
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_done: rsp_valid=%b need 0", bus.rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_ready;
        int         exp;
        reset_pulse();
        for (int i = 0; i < 4; i++) set_req(i, 32'(10 * i), 32'd1, 3'b000);
        #1;
        for (int n = 0; n < 5; n++) begin
            exp       = n % 4;
            exp_ready = 4'b0001 << exp;
            checks++;
            if (bus.req_ready !== exp_ready) begin
                errors++;
                $display("FAIL rr_grant%0d: req_ready=%b need %b", n, bus.req_ready, exp_ready);
            end
            tick();
            checks++;
            if (bus.req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL rr_pulse%0d: req_ready=%b need 0000", n, bus.req_ready);
            end
            tick();
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(exp) ||
                bus.rsp_result !== 32'(10 * exp + 1) || bus.req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL rr_rsp%0d: valid=%b id=%0d result=%0d ready=%b need 1/%0d/%0d/0000",
                         n, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.req_ready,
                         exp, 10 * exp + 1);
            end
            tick();
        end
        bus.req_valid = 4'b0000;
    endtask

    task automatic test_backpressure();
        reset_pulse();
        bus.rsp_ready = 1'b0;
        set_req(3, 32'hF0, 32'h0F, 3'b011);
        #1;
        checks++;
        if (bus.req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL bp_grant: req_ready=%b need 1000", bus.req_ready);
        end
        tick();
        bus.req_valid = 4'b0000;
        set_req(0, 32'hAA, 32'h11, 3'b000);
        tick();
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'hFF || bus.rsp_id !== 2'd3 ||
                bus.rsp_flags !== 4'b0000 || bus.req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b result=%h id=%0d flags=%b ready=%b",
                         j, bus.rsp_valid, bus.rsp_result, bus.rsp_id, bus.rsp_flags,
                         bus.req_ready);
            end
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL bp_release: valid=%b ready=%b need 0/0001", bus.rsp_valid,
                     bus.req_ready);
        end
`ifdef ALU_SHARE_ARB_PERF_EN
        checks++;
        if (perf_stall !== 32'd5 || perf_ops !== 32'd1) begin
            errors++;
            $display("FAIL bp_perf: stall=%0d ops=%0d need 5/1", perf_stall, perf_ops);
        end
`endif
        tick();
        bus.req_valid = 4'b0000;
        checks++;
        if (bus.alu_a !== 32'hAA || bus.alu_ctrl !== 3'b000) begin
            errors++;
            $display("FAIL bp_next: alu_a=%h ctrl=%b need aa/000", bus.alu_a, bus.alu_ctrl);
        end
        tick();
        checks++;
        if (bus.rsp_result !== 32'hBB || bus.rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL bp_next_rsp: result=%h id=%0d need bb/0", bus.rsp_result, bus.rsp_id);
        end
        tick();
    endtask

    task automatic test_slt_zero();
        set_req(2, 32'hFFFF_FFFF, 32'd1, 3'b101);
        #1;
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL slt_grant: req_ready=%b need 0100", bus.req_ready);
        end
        tick();
        bus.req_valid = 4'b0000;
        tick();
        checks++;
        if (bus.rsp_result !== 32'd1 || bus.rsp_err !== 1'b0 || bus.rsp_id !== 2'd2) begin
            errors++;
            $display("FAIL slt: result=%h err=%b id=%0d need 1/0/2", bus.rsp_result,
                     bus.rsp_err, bus.rsp_id);
        end
        tick();
        set_req(3, 32'd7, 32'd7, 3'b001);
        #1;
        checks++;
        if (bus.req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL zero_grant: req_ready=%b need 1000", bus.req_ready);
        end
        tick();
        bus.req_valid = 4'b0000;
        tick();
        checks++;
        if (bus.rsp_result !== 32'd0 || bus.rsp_flags !== 4'b1001 || bus.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL zero: result=%h flags=%b err=%b need 0/1001/0", bus.rsp_result,
                     bus.rsp_flags, bus.rsp_err);
        end
        tick();
    endtask

    task automatic test_illegal();
        reset_pulse();
        set_req(1, 32'd9, 32'd9, 3'b110);
        #1;
        checks++;
        if (bus.req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL ill_grant: req_ready=%b need 0010", bus.req_ready);
        end
        tick();
        bus.req_valid = 4'b0000;
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'd0 || bus.rsp_flags !== 4'b1000 ||
            bus.rsp_err !== 1'b1 || bus.rsp_id !== 2'd1) begin
            errors++;
            $display("FAIL illegal: valid=%b result=%h flags=%b err=%b id=%0d need 1/0/1000/1/1",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_flags, bus.rsp_err, bus.rsp_id);
        end
        tick();
        set_req(1, 32'd1, 32'd1, 3'b000);
        set_req(2, 32'd2, 32'd2, 3'b000);
        #1;
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL ill_ptr: req_ready=%b need 0100", bus.req_ready);
        end
        tick();
        bus.req_valid = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_op     = '0;
        bus.rsp_ready  = 1'b0;
        test_reset();
        test_single_op();
        test_round_robin();
        test_backpressure();
        test_slt_zero();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
